// File: rtl/term_arb_pkg.sv
// Shared types, constants and a reference round-robin pick helper for the
// terminal injection arbiter.
package term_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    localparam int PCKG_SZ = 40;
    localparam logic [PCKG_SZ-19:0] BCAST = {PCKG_SZ-18{1'b1}};

    localparam int RR_MAX_N = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } rr_pick_t;

    // Scans last+1, last+2, ... modulo n; walking downwards lets the nearest hit win.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                         input int unsigned        last,
                                         input int unsigned        n);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        if (n != 0) begin
            for (int k = RR_MAX_N; k >= 1; k--) begin
                if (k <= int'(n)) begin
                    idx = (last + k) % n;
                    if (req[idx]) begin
                        res.valid = 1'b1;
                        res.idx   = idx[4:0];
                    end
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin selector: rotate the request vector so the slot
// after 'last' is bit 0, priority-encode, then map the offset back to an index.
module rr_prio_sel #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner,
    output logic [N-1:0]     onehot
);

    logic [IDX_W:0]   start;
    logic [IDX_W:0]   offs;
    logic [IDX_W:0]   sum;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;

    // start may equal N (last == N-1); shifting the doubled vector by N yields req itself.
    always_comb begin
        start  = {1'b0, last} + 1'b1;
        dbl    = {req, req} >> start;
        rot    = dbl[N-1:0];
        offs   = '0;
        valid  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs  = (IDX_W+1)'(i);
                valid = 1'b1;
            end
        end
        sum = start + offs;
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        winner = sum[IDX_W-1:0];
        onehot = valid ? (N'(1) << winner) : '0;
    end

endmodule

// File: rtl/term_rr_arbiter.sv
// Round-robin arbiter feeding one mesh terminal from N requester FIFOs through a
// one-entry output register. Optional watchdog enabled by defining ARB_WDT_EN.
module term_rr_arbiter
    import term_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int pckg_sz = PCKG_SZ,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           pndng_in,
    input  logic [N*pckg_sz-1:0]   data_in,
    output logic [N-1:0]           pop,
    output logic [pckg_sz-1:0]     data_out,
    output logic                   pndng,
    input  logic                   popin,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   err
);

    localparam int IDX_W = $clog2(N);

    arb_state_t          state_q, state_d;
    logic [pckg_sz-1:0]  data_q, data_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;

    logic                canLoad;
    logic                load;
    logic                pickValid;
    logic [IDX_W-1:0]    winner;
    logic [N-1:0]        winnerOneHot;
    logic [pckg_sz-1:0]  winnerData;

    rr_prio_sel #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_sel (
        .req    (pndng_in),
        .last   (last_q),
        .valid  (pickValid),
        .winner (winner),
        .onehot (winnerOneHot)
    );

    assign canLoad = (state_q == EMPTY) | ((state_q == FULL) & popin);
    assign load    = canLoad & pickValid;
    assign pop     = load ? winnerOneHot : '0;

    always_comb begin
        winnerData = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IDX_W'(i)) begin
                winnerData = data_in[i*pckg_sz +: pckg_sz];
            end
        end
    end

    // A pop and a drain can coincide; the reload takes precedence and keeps pndng high.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (load) begin
            state_d = FULL;
            data_d  = winnerData;
            grant_d = winner;
            last_d  = winner;
        end else if ((state_q == FULL) && popin) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(N - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign data_out = data_q;
    assign pndng    = (state_q == FULL);
    assign grant_id = grant_q;

`ifdef ARB_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT + 1);

    logic [WDT_W-1:0] wdt_q;
    logic             err_q;

    // Counter saturates at TIMEOUT; the held packet is never dropped on expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else if (load) begin
            wdt_q <= '0;
        end else if ((state_q == FULL) && !popin && (wdt_q != WDT_W'(TIMEOUT))) begin
            wdt_q <= wdt_q + 1'b1;
            if (wdt_q + 1'b1 == WDT_W'(TIMEOUT)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_term_rr_arbiter.sv
// Self-checking bench for term_rr_arbiter: directed table, corner sequences and
// randomized traffic against a queue-free round-robin reference model.
module tb_term_rr_arbiter;
    import term_arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = PCKG_SZ;
    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     pndngIn = '0;
    logic [N*W-1:0]   dataIn = '0;
    logic             popin = 1'b0;
    logic [N-1:0]     pop;
    logic [W-1:0]     dataOut;
    logic             pndng;
    logic [1:0]       grantId;
    logic             err;

    term_rr_arbiter #(
        .N       (N),
        .pckg_sz (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng_in (pndngIn),
        .data_in  (dataIn),
        .pop      (pop),
        .data_out (dataOut),
        .pndng    (pndng),
        .popin    (popin),
        .grant_id (grantId),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] reqData [N];

    bit           mFull;
    logic [W-1:0] mData;
    int           mId;
    int           mLast;
    int           mCnt;
    bit           mErr;

    logic [N-1:0] sPop;
    logic         sPndng;
    logic [1:0]   sGrant;
    logic [W-1:0] sData;
    logic         sErr;

    typedef struct {
        logic [N-1:0] req;
        logic         popin;
        logic [N-1:0] expPop;
        logic         expPndng;
        logic [1:0]   expGrant;
        int           expSrc;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pickWinner(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mFull = 1'b0;
        mData = '0;
        mId   = 0;
        mLast = N - 1;
        mCnt  = 0;
        mErr  = 1'b0;
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance model.
    task automatic applyStimulus(input logic [N-1:0] req, input logic pin);
        int           w;
        logic [N-1:0] ePop;
        pndngIn = req;
        popin   = pin;
        for (int i = 0; i < N; i++) dataIn[i*W +: W] = reqData[i];
        w    = (!mFull || pin) ? pickWinner(req, mLast) : -1;
        ePop = (w >= 0) ? (N'(1) << w) : '0;
        @(negedge clk);
        sPop   = pop;
        sPndng = pndng;
        sGrant = grantId;
        sData  = dataOut;
        sErr   = err;
        checkOutput("model pop", 64'(sPop), 64'(ePop));
        checkOutput("model pndng", 64'(sPndng), 64'(mFull));
        checkOutput("model data_out", 64'(sData), 64'(mData));
        checkOutput("model grant_id", 64'(sGrant), 64'(mId));
        checkOutput("model err", 64'(sErr), 64'(mErr));
        @(posedge clk);
        #1;
        if (w >= 0) begin
            mData = reqData[w];
            mId   = w;
            mLast = w;
            mFull = 1'b1;
            mCnt  = 0;
        end else if (mFull && pin) begin
            mFull = 1'b0;
        end else if (mFull && !pin) begin
`ifdef ARB_WDT_EN
            if (mCnt < TMO) mCnt++;
            if (mCnt == TMO) mErr = 1'b1;
`endif
        end
    endtask

    task automatic pulseReset();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async rst pndng", 64'(pndng), 64'd0);
        checkOutput("async rst data_out", 64'(dataOut), 64'd0);
        checkOutput("async rst grant_id", 64'(grantId), 64'd0);
        checkOutput("async rst err", 64'(err), 64'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        modelReset();
        reqData[0] = {18'h3_0000, BCAST};
        reqData[1] = 40'hC1_1111_1111;
        reqData[2] = 40'hA5_0000_0001;
        reqData[3] = 40'hC3_3333_3333;

        // Reset held 50 ns with nothing pending.
        #20;
        checkOutput("reset pndng", 64'(pndng), 64'd0);
        checkOutput("reset pop", 64'(pop), 64'd0);
        checkOutput("reset data_out", 64'(dataOut), 64'd0);
        checkOutput("reset grant_id", 64'(grantId), 64'd0);
        #30;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0);

        // Single requester 2, no downstream acceptance.
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t2 pop", 64'(sPop), 64'b0100);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput("t2 pop once", 64'(sPop), 64'd0);
            checkOutput("t2 pndng", 64'(sPndng), 64'd1);
            checkOutput("t2 data_out", 64'(sData), 64'hA5_0000_0001);
            checkOutput("t2 grant_id", 64'(sGrant), 64'd2);
        end
        applyStimulus(4'b0000, 1'b1);
        pulseReset();

        reqData[2] = 40'hC2_2222_2222;
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, -1};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0,  0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1,  1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2,  2};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3,  3};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0,  0};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1,  1};
        vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2,  2};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3,  3};
        vecs[9]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd0,  0};
        vecs[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1,  1};
        vecs[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1,  1};
        vecs[12] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd3,  3};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3,  3};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3,  3};
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3,  3};
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] expData;
            applyStimulus(vecs[i].req, vecs[i].popin);
            expData = (vecs[i].expSrc < 0) ? '0 : reqData[vecs[i].expSrc];
            checkOutput($sformatf("vec%0d pop", i), 64'(sPop), 64'(vecs[i].expPop));
            checkOutput($sformatf("vec%0d pndng", i), 64'(sPndng), 64'(vecs[i].expPndng));
            checkOutput($sformatf("vec%0d grant_id", i), 64'(sGrant), 64'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d data_out", i), 64'(sData), 64'(expData));
        end

        // Asynchronous reset while holding a packet; requester 0 must win afterwards.
        pulseReset();
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t5 loaded", 64'(sPndng), 64'd1);
        pulseReset();
        applyStimulus(4'b1111, 1'b0);
        checkOutput("t5 first pop", 64'(sPop), 64'b0001);
        applyStimulus(4'b1110, 1'b0);
        checkOutput("t5 first grant", 64'(sGrant), 64'd0);
        applyStimulus(4'b1110, 1'b1);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) reqData[i] = {8'($urandom), $urandom};
            applyStimulus(N'($urandom), ($urandom_range(0, 3) != 0));
        end

        pulseReset();
        applyStimulus(4'b0001, 1'b0);
`ifdef ARB_WDT_EN
        for (int k = 1; k <= TMO; k++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput($sformatf("wdt err before %0d", k), 64'(sErr), 64'd0);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("wdt err set", 64'(sErr), 64'd1);
        checkOutput("wdt packet held", 64'(sPndng), 64'd1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("wdt err sticky", 64'(sErr), 64'd1);
        checkOutput("wdt drained", 64'(sPndng), 64'd0);
        pulseReset();
`else
        for (int k = 0; k < 2 * TMO; k++) applyStimulus(4'b0000, 1'b0);
        checkOutput("no wdt err", 64'(sErr), 64'd0);
        checkOutput("no wdt held", 64'(sPndng), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
